// File: rtl/ram_loader_pkg.sv
// Shared types for the byte-stream RAM loader.
// Holds the FSM state enum, error codes and the frame length width.
package ram_loader_pkg;

    localparam int LEN_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_LEN  = 2'b01,
        ERR_CSUM = 2'b10
    } err_t;

endpackage

// File: rtl/ram_loader_if.sv
// Byte stream valid/ready channel feeding the loader.
// Ports: in_data/in_valid from master, in_ready from slave.
interface ram_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/ram_loader_checksum.sv
// 8-bit running sum (mod 256) of payload bytes.
// Ports: clock, reset_n, i_clear, i_add, i_byte in; o_sum out.
module loader_checksum (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_add,
    input  logic [7:0] i_byte,
    output logic [7:0] o_sum
);

    logic [7:0] r_sum;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sum <= 8'h00;
        end else if (i_clear) begin
            r_sum <= 8'h00;
        end else if (i_add) begin
            r_sum <= r_sum + i_byte;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/ram_loader.sv
// Framed byte-stream loader: LEN_LO LEN_HI payload CSUM -> RAM.
// Ports: clock, reset_n, start, stream (slave), RAM write bus, status.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int                   addr_bits    = 16,
    parameter int                   data_bits    = 8,
    parameter logic [addr_bits-1:0] base_address = '0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    ram_loader_if.slave          stream,
    output logic                 ram_write_enable,
    output logic [addr_bits-1:0] ram_address,
    output logic [data_bits-1:0] ram_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           error_code,
    output logic [addr_bits:0]   bytes_loaded
);

    // Wide enough for both base+N and the 16-bit length itself.
    localparam int CW = (addr_bits + 1 > LEN_BITS + 1) ?
                        addr_bits + 1 : LEN_BITS + 1;

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_len_lo;
    logic [LEN_BITS-1:0]   r_len;
    logic [addr_bits:0]    r_idx;
    logic                  r_we;
    logic [addr_bits-1:0]  r_addr;
    logic [data_bits-1:0]  r_data;
    logic                  r_done;
    logic                  r_error;
    err_t                  r_err;

    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_start_ok;
    logic [LEN_BITS-1:0]   w_n;
    logic [CW-1:0]         w_end;
    logic                  w_ovf;
    logic [addr_bits:0]    w_idx_nx;
    logic                  w_last;
    logic [7:0]            w_sum;
    logic                  w_csum_ok;

    assign w_ready = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                     (r_state == DATA)   || (r_state == CSUM);
    assign w_xfer  = w_ready && stream.in_valid;

    assign w_start_ok = start && ((r_state == IDLE) ||
                                  (r_state == DONE) ||
                                  (r_state == ERROR));

    assign w_n   = {stream.in_data, r_len_lo};
    assign w_end = CW'(base_address) + CW'(w_n);
    assign w_ovf = w_end > (CW'(1) << addr_bits);

    assign w_idx_nx  = r_idx + 1'b1;
    assign w_last    = CW'(w_idx_nx) == CW'(r_len);
    assign w_csum_ok = w_sum == stream.in_data;

    loader_checksum u_csum (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clear (w_start_ok),
        .i_add   (w_xfer && (r_state == DATA)),
        .i_byte  (stream.in_data),
        .o_sum   (w_sum)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE, ERROR: begin
                if (w_start_ok) w_next = LEN_LO;
            end
            LEN_LO: begin
                if (w_xfer) w_next = LEN_HI;
            end
            LEN_HI: begin
                if (w_xfer) begin
                    if (w_ovf)          w_next = ERROR;
                    else if (w_n == '0) w_next = CSUM;
                    else                w_next = DATA;
                end
            end
            DATA: begin
                if (w_xfer && w_last) w_next = CSUM;
            end
            CSUM: begin
                if (w_xfer) w_next = w_csum_ok ? DONE : ERROR;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_len_lo <= 8'h00;
            r_len    <= '0;
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_addr   <= base_address;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_err    <= ERR_NONE;
        end else begin
            // Write strobe lives exactly one cycle per accepted byte.
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_idx   <= '0;
                r_done  <= 1'b0;
                r_error <= 1'b0;
                r_err   <= ERR_NONE;
            end
            if (w_xfer) begin
                unique case (r_state)
                    LEN_LO: r_len_lo <= stream.in_data;
                    LEN_HI: begin
                        r_len <= w_n;
                        if (w_ovf) begin
                            r_error <= 1'b1;
                            r_err   <= ERR_LEN;
                        end
                    end
                    DATA: begin
                        r_we   <= 1'b1;
                        r_addr <= base_address + r_idx[addr_bits-1:0];
                        r_data <= data_bits'(stream.in_data);
                        r_idx  <= w_idx_nx;
                    end
                    CSUM: begin
                        if (w_csum_ok) begin
                            r_done <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                            r_err   <= ERR_CSUM;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign stream.in_ready  = w_ready;
    assign busy             = w_ready;
    assign ram_write_enable = r_we;
    assign ram_address      = r_addr;
    assign ram_data         = r_data;
    assign done             = r_done;
    assign error            = r_error;
    assign error_code       = r_err;
    assign bytes_loaded     = r_idx;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: scoreboard of expected RAM writes
// compared against writes captured at the RAM sampling edge.
module tb_ram_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;

    ram_loader_if ifa();
    ram_loader_if ifb();

    logic        a_we, b_we;
    logic [15:0] a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic        a_busy, b_busy, a_done, b_done, a_err, b_err;
    logic [1:0]  a_code, b_code;
    logic [16:0] a_bytes, b_bytes;

    int total = 0;
    int fails = 0;
    logic [23:0] exp_q[$];
    logic [23:0] obs_a[$];
    logic [23:0] obs_b[$];
    int rd_a = 0;
    int rd_b = 0;

    ram_loader #(.addr_bits(16), .data_bits(8), .base_address(16'h0000)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .stream(ifa),
        .ram_write_enable(a_we), .ram_address(a_addr), .ram_data(a_data),
        .busy(a_busy), .done(a_done), .error(a_err), .error_code(a_code),
        .bytes_loaded(a_bytes)
    );

    ram_loader #(.addr_bits(16), .data_bits(8), .base_address(16'hFFFE)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .stream(ifb),
        .ram_write_enable(b_we), .ram_address(b_addr), .ram_data(b_data),
        .busy(b_busy), .done(b_done), .error(b_err), .error_code(b_code),
        .bytes_loaded(b_bytes)
    );

    always #5 clock = ~clock;

    // RAM samples on the negedge between write cycles.
    always @(negedge clock) begin
        if (a_we) obs_a.push_back({a_addr, a_data});
        if (b_we) obs_b.push_back({b_addr, b_data});
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ifa.in_ready : ifb.in_ready;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int sel, input logic [7:0] b);
        int n;
        n = 0;
        if (sel == 0) begin
            ifa.in_data = b; ifa.in_valid = 1'b1;
        end else begin
            ifb.in_data = b; ifb.in_valid = 1'b1;
        end
        while (!rdy(sel) && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(n < 20), 32'd1);
        tick();
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] d);
        exp_q.push_back({addr, d});
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic drain(input int sel);
        logic [23:0] e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 'x;
            if (sel == 0) begin
                if (rd_a < obs_a.size()) o = obs_a[rd_a];
                rd_a++;
            end else begin
                if (rd_b < obs_b.size()) o = obs_b[rd_b];
                rd_b++;
            end
            check("ram_write", 32'(o), 32'(e));
        end
        if (sel == 0) check("write_count_a", obs_a.size(), rd_a);
        else          check("write_count_b", obs_b.size(), rd_b);
    endtask

    task automatic status_a(input logic d, input logic e, input logic [1:0] c,
                            input logic [16:0] n, input logic bz);
        check("done_a", 32'(a_done), 32'(d));
        check("error_a", 32'(a_err), 32'(e));
        check("code_a", 32'(a_code), 32'(c));
        check("bytes_a", 32'(a_bytes), 32'(n));
        check("busy_a", 32'(a_busy), 32'(bz));
    endtask

    initial begin
        ifa.in_data = 8'h00; ifa.in_valid = 1'b0;
        ifb.in_data = 8'h00; ifb.in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(ifa.in_ready), 32'd0);
        check("rst_we", 32'(a_we), 32'd0);
        check("rst_addr_a", 32'(a_addr), 32'h0);
        check("rst_addr_b", 32'(b_addr), 32'hFFFE);
        check("rst_data", 32'(a_data), 32'h0);
        status_a(1'b0, 1'b0, 2'b00, 17'd0, 1'b0);
        reset_n = 1'b1;
        tick();

        // Normal 3-byte frame.
        pulse_start(0);
        check("busy_armed", 32'(a_busy), 32'd1);
        send(0, 8'h03); send(0, 8'h00);
        wr(16'h0000, 8'h11); send(0, 8'h11);
        wr(16'h0001, 8'h22); send(0, 8'h22);
        wr(16'h0002, 8'h33); send(0, 8'h33);
        send(0, 8'h66);
        tick();
        status_a(1'b1, 1'b0, 2'b00, 17'd3, 1'b0);
        check("ready_done", 32'(ifa.in_ready), 32'd0);
        drain(0);

        // Zero-length frame.
        pulse_start(0);
        check("done_cleared", 32'(a_done), 32'd0);
        send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
        tick();
        status_a(1'b1, 1'b0, 2'b00, 17'd0, 1'b0);
        drain(0);

        // Checksum mismatch: payload stays written.
        pulse_start(0);
        send(0, 8'h02); send(0, 8'h00);
        wr(16'h0000, 8'hAA); send(0, 8'hAA);
        wr(16'h0001, 8'hBB); send(0, 8'hBB);
        send(0, 8'h00);
        tick();
        status_a(1'b0, 1'b1, 2'b10, 17'd2, 1'b0);
        drain(0);

        // Length overflow on base FFFE.
        pulse_start(1);
        send(1, 8'h03); send(1, 8'h00);
        check("ovf_error", 32'(b_err), 32'd1);
        check("ovf_code", 32'(b_code), 32'h1);
        check("ovf_busy", 32'(b_busy), 32'd0);
        check("ovf_bytes", 32'(b_bytes), 32'd0);
        tick();
        drain(1);

        // Exact fit at top of address space.
        pulse_start(1);
        check("ovf_cleared", 32'(b_code), 32'h0);
        send(1, 8'h02); send(1, 8'h00);
        wr(16'hFFFE, 8'h01); send(1, 8'h01);
        wr(16'hFFFF, 8'h02); send(1, 8'h02);
        send(1, 8'h03);
        tick();
        check("fit_done", 32'(b_done), 32'd1);
        check("fit_bytes", 32'(b_bytes), 32'd2);
        drain(1);

        // Gapped input, then mid-frame reset.
        pulse_start(0);
        send(0, 8'h04); send(0, 8'h00);
        wr(16'h0000, 8'hC1); send(0, 8'hC1);
        tick();
        check("gap_we", 32'(a_we), 32'd0);
        check("gap_bytes", 32'(a_bytes), 32'd1);
        wr(16'h0001, 8'hC2); send(0, 8'hC2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_ready", 32'(ifa.in_ready), 32'd0);
        check("abort_addr", 32'(a_addr), 32'h0);
        status_a(1'b0, 1'b0, 2'b00, 17'd0, 1'b0);
        ifa.in_valid = 1'b1;
        ifa.in_data = 8'hC3;
        tick(); tick(); tick();
        ifa.in_valid = 1'b0;
        drain(0);

        // Fresh frame after reset.
        pulse_start(0);
        send(0, 8'h01); send(0, 8'h00);
        wr(16'h0000, 8'h5A); send(0, 8'h5A);
        send(0, 8'h5A);
        tick();
        status_a(1'b1, 1'b0, 2'b00, 17'd1, 1'b0);
        drain(0);

        // start during DATA is ignored.
        pulse_start(0);
        send(0, 8'h03); send(0, 8'h00);
        wr(16'h0000, 8'h10); send(0, 8'h10);
        start_a = 1'b1;
        wr(16'h0001, 8'h20); send(0, 8'h20);
        start_a = 1'b0;
        check("mid_start_busy", 32'(a_busy), 32'd1);
        wr(16'h0002, 8'h30); send(0, 8'h30);
        send(0, 8'h60);
        tick();
        status_a(1'b1, 1'b0, 2'b00, 17'd3, 1'b0);
        drain(0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
